// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcode and register encodings, plus the leapfrog tracker state.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        LF_IDLE = 2'b00,
        LF_LEAP = 2'b01,
        LF_FULL = 2'b10
    } leapfrog_state_t;

    // Memory-touching or trapping instructions can never retire ahead of MEM.
    function automatic logic is_mem_op(input lc3b_opcode op);
        case (op)
            op_ldr, op_ldi, op_ldb,
            op_str, op_sti, op_stb,
            op_trap: is_mem_op = 1'b1;
            default: is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_alu_dest_op(input lc3b_opcode op);
        case (op)
            op_add, op_and, op_not, op_lea, op_shf: is_alu_dest_op = 1'b1;
            default:                                is_alu_dest_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/leapfrog_qualify.sv
// Combinational check of whether the EX instruction may retire past a stalled MEM.
// Optional feature: LEAPFROG_CC_BR_EN lets a branch pass a CC-loading MEM once a leapfrogger owns the CC.
module leapfrog_qualify
    import lc3b_types::*;
(
    input  lc3b_opcode opcode,
    input  lc3b_reg    sr1_in,
    input  lc3b_reg    sr2_in,
    input  lc3b_reg    mem_dest,
    input  logic       mem_dest_write,
    input  logic       mem_load_cc,
    input  lc3b_opcode mem_opcode,
    input  logic       cc_sticky,
    output logic       eligible
);

    logic raw_hazard_s;
    logic br_block_s;

    // Eligibility: no RAW on MEM's result, no memory op, no CC-dependent branch, no trap in MEM.
    always_comb begin
        raw_hazard_s = mem_dest_write && ((sr1_in == mem_dest) || (sr2_in == mem_dest));
`ifdef LEAPFROG_CC_BR_EN
        br_block_s   = (opcode == op_br) && mem_load_cc && !cc_sticky;
`else
        br_block_s   = (opcode == op_br) && mem_load_cc;
`endif
        eligible     = !raw_hazard_s && !is_mem_op(opcode) && !br_block_s
                       && (mem_opcode != op_trap);
    end

`ifndef LEAPFROG_CC_BR_EN
    logic unused_s;
    assign unused_s = cc_sticky;
`endif

endmodule

// File: rtl/leapfrog_tracker.sv
// Tracks EX instructions retiring past a stalled MEM instruction and suppresses
// MEM's stale register/CC writes. Optional feature macro: LEAPFROG_CC_BR_EN.
module leapfrog_tracker
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ex_valid,
    input  lc3b_opcode                 opcode,
    input  lc3b_reg                    sr1_in,
    input  lc3b_reg                    sr2_in,
    input  lc3b_reg                    dest_in,
    input  logic                       dest_write,
    input  logic                       load_cc,
    input  logic                       mem_stall,
    input  lc3b_opcode                 mem_opcode,
    input  lc3b_reg                    mem_dest,
    input  logic                       mem_dest_write,
    input  logic                       mem_load_cc,
    output logic                       leapfrog_load,
    output logic                       mem_dest_overwrite,
    output logic                       mem_load_cc_overwrite,
    output logic [$clog2(DEPTH+1)-1:0] leap_count,
    output logic                       leap_full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    leapfrog_state_t state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            dest_sticky_q, dest_sticky_d;
    logic            cc_sticky_q, cc_sticky_d;

    logic eligible_s;
    logic mem_trap_s;
    logic dest_hit_s;
    logic cc_hit_s;

    leapfrog_qualify u_qualify (
        .opcode         (opcode),
        .sr1_in         (sr1_in),
        .sr2_in         (sr2_in),
        .mem_dest       (mem_dest),
        .mem_dest_write (mem_dest_write),
        .mem_load_cc    (mem_load_cc),
        .mem_opcode     (mem_opcode),
        .cc_sticky      (cc_sticky_q),
        .eligible       (eligible_s)
    );

    // Zero-latency leapfrog decision and overwrite outputs.
    always_comb begin
        mem_trap_s    = (mem_opcode == op_trap);
        leapfrog_load = mem_stall && ex_valid && (state_q != LF_FULL) && eligible_s;
        dest_hit_s    = leapfrog_load && dest_write && mem_dest_write && !mem_trap_s
                        && (dest_in == mem_dest) && is_alu_dest_op(opcode);
        cc_hit_s      = leapfrog_load && load_cc && !mem_trap_s;
        mem_dest_overwrite    = !mem_trap_s && (dest_sticky_q || dest_hit_s);
        mem_load_cc_overwrite = !mem_trap_s && (cc_sticky_q || cc_hit_s);
    end

    // Next-state: stall release clears everything; otherwise count leapfrogs and latch hits.
    always_comb begin
        count_d       = count_q;
        dest_sticky_d = dest_sticky_q;
        cc_sticky_d   = cc_sticky_q;
        state_d       = state_q;
        if (!mem_stall) begin
            count_d       = '0;
            dest_sticky_d = 1'b0;
            cc_sticky_d   = 1'b0;
        end else if (leapfrog_load) begin
            if (count_q != DEPTH_C) begin
                count_d = count_q + CW'(1'b1);
            end else begin
                count_d = count_q;
            end
            dest_sticky_d = dest_sticky_q || dest_hit_s;
            cc_sticky_d   = cc_sticky_q || cc_hit_s;
        end else begin
            count_d = count_q;
        end

        if (count_d == '0) begin
            state_d = LF_IDLE;
        end else if (count_d == DEPTH_C) begin
            state_d = LF_FULL;
        end else begin
            state_d = LF_LEAP;
        end
        full_d = (count_d == DEPTH_C);
    end

    // Tracker state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= LF_IDLE;
            count_q       <= '0;
            full_q        <= 1'b0;
            dest_sticky_q <= 1'b0;
            cc_sticky_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            full_q        <= full_d;
            dest_sticky_q <= dest_sticky_d;
            cc_sticky_q   <= cc_sticky_d;
        end
    end

    assign leap_count = count_q;
    assign leap_full  = full_q;

endmodule

// File: tb/tb_leapfrog_tracker.sv
// Directed self-checking bench for leapfrog_tracker (DEPTH = 4).
module tb_leapfrog_tracker;
    import lc3b_types::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_valid;
    lc3b_opcode opcode;
    lc3b_reg    sr1_in, sr2_in, dest_in;
    logic       dest_write, load_cc;
    logic       mem_stall;
    lc3b_opcode mem_opcode;
    lc3b_reg    mem_dest;
    logic       mem_dest_write, mem_load_cc;
    logic       leapfrog_load, mem_dest_overwrite, mem_load_cc_overwrite;
    logic [2:0] leap_count;
    logic       leap_full;

    int n_total = 0;
    int n_pass  = 0;

    leapfrog_tracker #(.DEPTH(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ex_valid              (ex_valid),
        .opcode                (opcode),
        .sr1_in                (sr1_in),
        .sr2_in                (sr2_in),
        .dest_in               (dest_in),
        .dest_write            (dest_write),
        .load_cc               (load_cc),
        .mem_stall             (mem_stall),
        .mem_opcode            (mem_opcode),
        .mem_dest              (mem_dest),
        .mem_dest_write        (mem_dest_write),
        .mem_load_cc           (mem_load_cc),
        .leapfrog_load         (leapfrog_load),
        .mem_dest_overwrite    (mem_dest_overwrite),
        .mem_load_cc_overwrite (mem_load_cc_overwrite),
        .leap_count            (leap_count),
        .leap_full             (leap_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_alu(input lc3b_opcode op, input lc3b_reg d, input lc3b_reg s1,
                          input lc3b_reg s2, input logic cc);
        ex_valid   = 1'b1;
        opcode     = op;
        dest_in    = d;
        sr1_in     = s1;
        sr2_in     = s2;
        dest_write = (op != op_br);
        load_cc    = cc;
    endtask

    task automatic mem_ldr_r1();
        mem_stall      = 1'b1;
        mem_opcode     = op_ldr;
        mem_dest       = 3'd1;
        mem_dest_write = 1'b1;
        mem_load_cc    = 1'b1;
    endtask

    task automatic release_stall();
        ex_valid  = 1'b0;
        mem_stall = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; ex_valid = 1'b0; opcode = op_add; sr1_in = 3'd0; sr2_in = 3'd0;
        dest_in = 3'd0; dest_write = 1'b0; load_cc = 1'b0; mem_stall = 1'b0;
        mem_opcode = op_add; mem_dest = 3'd0; mem_dest_write = 1'b0; mem_load_cc = 1'b0;
        #3;
        chk("reset_count", leap_count, 0);
        chk("reset_full", leap_full, 0);
        chk("reset_ld", leapfrog_load, 0);
        chk("reset_dov", mem_dest_overwrite, 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Independent add leapfrogs a stalled ldr R1
        mem_ldr_r1();
        ex_alu(op_add, 3'd2, 3'd3, 3'd4, 1'b0);
        #1;
        chk("indep_ld", leapfrog_load, 1);
        chk("indep_dov", mem_dest_overwrite, 0);
        chk("indep_cov", mem_load_cc_overwrite, 0);
        chk("indep_cnt0", leap_count, 0);
        tick();
        chk("indep_cnt1", leap_count, 1);
        ex_valid = 1'b0;
        #1;
        chk("bubble_ld", leapfrog_load, 0);
        release_stall();
        chk("release_cnt", leap_count, 0);

        // Hazards and ineligible instructions
        mem_ldr_r1();
        ex_alu(op_add, 3'd2, 3'd1, 3'd3, 1'b0);
        #1;
        chk("raw_sr1_ld", leapfrog_load, 0);
        tick();
        chk("raw_sr1_cnt", leap_count, 0);
        sr1_in = 3'd3; sr2_in = 3'd1;
        #1;
        chk("raw_sr2_ld", leapfrog_load, 0);
        ex_alu(op_ldr, 3'd2, 3'd3, 3'd4, 1'b0);
        #1;
        chk("ex_ldr_ld", leapfrog_load, 0);
        ex_alu(op_sti, 3'd2, 3'd3, 3'd4, 1'b0);
        #1;
        chk("ex_sti_ld", leapfrog_load, 0);
        ex_alu(op_br, 3'd0, 3'd0, 3'd0, 1'b0);
        #1;
        chk("br_ccdep_ld", leapfrog_load, 0);
        mem_load_cc = 1'b0;
        #1;
        chk("br_nocc_ld", leapfrog_load, 1);
        release_stall();

        // Trap in MEM blocks everything
        mem_ldr_r1();
        mem_opcode = op_trap;
        ex_alu(op_add, 3'd1, 3'd2, 3'd3, 1'b1);
        #1;
        chk("trap_ld", leapfrog_load, 0);
        chk("trap_dov", mem_dest_overwrite, 0);
        chk("trap_cov", mem_load_cc_overwrite, 0);
        tick();
        chk("trap_cnt", leap_count, 0);
        release_stall();

        // Same destination: both overwrites, held through the stall-release cycle
        mem_ldr_r1();
        ex_alu(op_add, 3'd1, 3'd2, 3'd3, 1'b1);
        #1;
        chk("ovr_ld", leapfrog_load, 1);
        chk("ovr_dov_now", mem_dest_overwrite, 1);
        chk("ovr_cov_now", mem_load_cc_overwrite, 1);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("ovr_dov_sticky", mem_dest_overwrite, 1);
        chk("ovr_cov_sticky", mem_load_cc_overwrite, 1);
        mem_stall = 1'b0;
        #1;
        chk("ovr_dov_fall", mem_dest_overwrite, 1);
        chk("ovr_cov_fall", mem_load_cc_overwrite, 1);
        tick();
        chk("ovr_dov_clear", mem_dest_overwrite, 0);
        chk("ovr_cov_clear", mem_load_cc_overwrite, 0);
        chk("ovr_cnt_clear", leap_count, 0);

        // Non-ALU writer to same dest does not trigger dest overwrite
        mem_ldr_r1();
        ex_alu(op_jsr, 3'd1, 3'd2, 3'd3, 1'b0);
        #1;
        chk("jsr_ld", leapfrog_load, 1);
        chk("jsr_dov", mem_dest_overwrite, 0);
        release_stall();

        // Saturation at DEPTH over a 6-cycle stall
        mem_ldr_r1();
        ex_alu(op_add, 3'd2, 3'd3, 3'd4, 1'b0);
        #1;
        chk("sat_ld_c1", leapfrog_load, 1);
        tick(); chk("sat_cnt1", leap_count, 1);
        tick(); chk("sat_cnt2", leap_count, 2);
        tick(); chk("sat_cnt3", leap_count, 3);
        chk("sat_full3", leap_full, 0);
        tick(); chk("sat_cnt4", leap_count, 4);
        chk("sat_full4", leap_full, 1);
        chk("sat_ld_c5", leapfrog_load, 0);
        tick(); chk("sat_cnt_hold", leap_count, 4);
        chk("sat_ld_c6", leapfrog_load, 0);
        release_stall();
        chk("sat_cnt_rel", leap_count, 0);
        chk("sat_full_rel", leap_full, 0);

        // CC-producing add leapfrogs, then a branch follows
        mem_ldr_r1();
        ex_alu(op_add, 3'd2, 3'd3, 3'd4, 1'b1);
        #1;
        chk("cc_add_ld", leapfrog_load, 1);
        chk("cc_add_cov", mem_load_cc_overwrite, 1);
        tick();
        ex_alu(op_br, 3'd0, 3'd0, 3'd0, 1'b0);
        #1;
`ifdef LEAPFROG_CC_BR_EN
        chk("br_after_cc_ld", leapfrog_load, 1);
`else
        chk("br_after_cc_ld", leapfrog_load, 0);
`endif
        release_stall();

        // Asynchronous reset mid-stall at count 2
        mem_ldr_r1();
        ex_alu(op_add, 3'd2, 3'd3, 3'd4, 1'b1);
        tick();
        tick();
        ex_valid = 1'b0;
        #1;
        chk("rst_pre_cnt", leap_count, 2);
        chk("rst_pre_cov", mem_load_cc_overwrite, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_cnt", leap_count, 0);
        chk("rst_mid_cov", mem_load_cc_overwrite, 0);
        chk("rst_mid_full", leap_full, 0);
        tick();
        reset = 1'b0;
        ex_valid = 1'b1;
        #1;
        chk("rst_after_ld", leapfrog_load, 1);
        tick();
        chk("rst_after_cnt", leap_count, 1);
        release_stall();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
